// File: rtl/wb_regfile.sv
// Writeback stage: EXE/WB pipeline register plus register file with two bypassed combinational read ports.
// Capture at edge N, commit at edge N+1. stall_i holds the WB register, and flush_i (which wins over stall) loads a bubble.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  exe_we_i,
  input  logic [ADDR_WIDTH-1:0] exe_waddr_i,
  input  logic [DATA_WIDTH-1:0] exe_wdata_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  re1_i,
  input  logic                  re2_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_waddr_o,
  output logic [DATA_WIDTH-1:0] wb_wdata_o
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_t;

  wb_t                   wb_q;
  logic [DATA_WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_q <= '0;
    end else if (flush_i) begin
      wb_q <= '0;
    end else if (!stall_i) begin
      wb_q <= {exe_we_i, exe_waddr_i, exe_wdata_i};
    end
  end

  // Commit ignores stall. A held entry simply rewrites the same value each cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_q.we && (wb_q.waddr != '0)) begin
      regs[wb_q.waddr] <= wb_q.wdata;
    end
  end

  // The youngest producer wins: EXE first, then the WB register, then the array.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic re,
                                                      input logic [ADDR_WIDTH-1:0] ra);
    logic [DATA_WIDTH-1:0] d;
    if (!re || (ra == '0))                   d = '0;
    else if (exe_we_i && (exe_waddr_i == ra)) d = exe_wdata_i;
    else if (wb_q.we && (wb_q.waddr == ra))   d = wb_q.wdata;
    else                                      d = regs[ra];
    return d;
  endfunction

  assign rdata1_o   = read_port(re1_i, raddr1_i);
  assign rdata2_o   = read_port(re2_i, raddr2_i);

  assign wb_we_o    = wb_q.we;
  assign wb_waddr_o = wb_q.waddr;
  assign wb_wdata_o = wb_q.wdata;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed checks of wb_regfile against an array-based reference model.
module tb_wb_regfile;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        exe_we_i;
  logic [4:0]  exe_waddr_i;
  logic [31:0] exe_wdata_i;
  logic        stall_i, flush_i, re1_i, re2_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  int tests = 0;
  int fails = 0;

  // Reference model: the architectural registers plus the pending writeback entry.
  logic [31:0] m_regs [32];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .exe_we_i(exe_we_i), .exe_waddr_i(exe_waddr_i), .exe_wdata_i(exe_wdata_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .re1_i(re1_i), .re2_i(re2_i), .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_we = 1'b0; m_wa = '0; m_wd = '0;
  endtask

  function automatic logic [31:0] model_read(input logic re, input logic [4:0] ra);
    if (!re || ra == 0)                   return 32'h0;
    if (exe_we_i && exe_waddr_i == ra)    return exe_wdata_i;
    if (m_we && m_wa == ra)               return m_wd;
    return m_regs[ra];
  endfunction

  // Advance one clock. The model applies the edge, then control returns at the next falling edge.
  task automatic tick();
    @(posedge clk_i);
    if (m_we && m_wa != 0) m_regs[m_wa] = m_wd;
    if (flush_i) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else if (!stall_i) begin
      m_we = exe_we_i; m_wa = exe_waddr_i; m_wd = exe_wdata_i;
    end
    @(negedge clk_i);
  endtask

  task automatic set_exe(input logic we, input logic [4:0] a, input logic [31:0] d);
    exe_we_i = we; exe_waddr_i = a; exe_wdata_i = d;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    set_exe(1'b0, 5'd0, 32'h0);
    stall_i = 0; flush_i = 0;
    re1_i = 1; re2_i = 1; raddr1_i = 5'd9; raddr2_i = 5'd31;
    #3;
    tests++;
    if (wb_we_o !== 1'b0 || wb_waddr_o !== 5'd0 || wb_wdata_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_wb: got we=%b a=%0d d=%h expected 0/0/0", wb_we_o, wb_waddr_o, wb_wdata_o);
    end
    tests++;
    if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h %h expected 0 0", rdata1_o, rdata2_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_commit();
    set_exe(1'b1, 5'd3, 32'hDEADBEEF);
    re2_i = 1; raddr2_i = 5'd3;
    #1;
    tests++;
    if (rdata2_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL commit_exe_bypass: got %h expected deadbeef", rdata2_o);
    end
    tick();
    set_exe(1'b0, 5'd0, 32'h0);
    #1;
    tests++;
    if (rdata2_o !== 32'hDEADBEEF || wb_we_o !== 1'b1 || wb_waddr_o !== 5'd3) begin
      fails++;
      $display("FAIL commit_s_bypass: got rd=%h we=%b a=%0d expected deadbeef 1 3", rdata2_o, wb_we_o, wb_waddr_o);
    end
    tick();
    tick();
    #1;
    tests++;
    if (rdata2_o !== 32'hDEADBEEF || wb_we_o !== 1'b0) begin
      fails++; $display("FAIL commit_array: got rd=%h we=%b expected deadbeef 0", rdata2_o, wb_we_o);
    end
  endtask

  task automatic test_x0();
    set_exe(1'b1, 5'd0, 32'hFFFFFFFF);
    re1_i = 1; raddr1_i = 5'd0;
    #1;
    tests++;
    if (rdata1_o !== 32'h0) begin
      fails++; $display("FAIL x0_exe: got %h expected 0", rdata1_o);
    end
    tick();
    set_exe(1'b0, 5'd0, 32'h0);
    #1;
    tests++;
    if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd0 || wb_wdata_o !== 32'hFFFFFFFF || rdata1_o !== 32'h0) begin
      fails++;
      $display("FAIL x0_s: got we=%b a=%0d d=%h rd=%h expected 1 0 ffffffff 0", wb_we_o, wb_waddr_o, wb_wdata_o, rdata1_o);
    end
    tick();
    #1;
    tests++;
    if (rdata1_o !== 32'h0) begin
      fails++; $display("FAIL x0_array: got %h expected 0", rdata1_o);
    end
  endtask

  task automatic test_bypass_priority();
    set_exe(1'b1, 5'd7, 32'h11);
    tick();
    set_exe(1'b1, 5'd7, 32'h22);
    re1_i = 1; raddr1_i = 5'd7;
    #1;
    tests++;
    if (rdata1_o !== 32'h22 || wb_wdata_o !== 32'h11) begin
      fails++; $display("FAIL bypass_prio: got rd=%h s=%h expected 22 11", rdata1_o, wb_wdata_o);
    end
    tick();
    set_exe(1'b0, 5'd0, 32'h0);
    tick();
    #1;
    tests++;
    if (rdata1_o !== 32'h22 || wb_we_o !== 1'b0) begin
      fails++; $display("FAIL bypass_array: got rd=%h we=%b expected 22 0", rdata1_o, wb_we_o);
    end
  endtask

  task automatic test_stall_flush();
    set_exe(1'b1, 5'd4, 32'hAA);
    re1_i = 1; raddr1_i = 5'd4;
    tick();
    stall_i = 1;
    for (int c = 0; c < 3; c++) begin
      set_exe(1'b1, 5'd9, 32'h55 + c);
      tick();
      #1;
      tests++;
      if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd4 || wb_wdata_o !== 32'hAA || rdata1_o !== 32'hAA) begin
        fails++;
        $display("FAIL stall_hold%0d: got we=%b a=%0d d=%h rd=%h expected 1 4 aa aa", c, wb_we_o, wb_waddr_o, wb_wdata_o, rdata1_o);
      end
    end
    flush_i = 1;
    set_exe(1'b1, 5'd4, 32'hBB);
    #1;
    tests++;
    if (rdata1_o !== 32'hBB) begin
      fails++; $display("FAIL flush_exe_bypass: got %h expected bb", rdata1_o);
    end
    tick();
    flush_i = 0; stall_i = 0;
    set_exe(1'b0, 5'd0, 32'h0);
    #1;
    tests++;
    if (wb_we_o !== 1'b0 || wb_waddr_o !== 5'd0 || wb_wdata_o !== 32'h0 || rdata1_o !== 32'hAA) begin
      fails++;
      $display("FAIL flush_bubble: got we=%b a=%0d d=%h rd=%h expected 0 0 0 aa", wb_we_o, wb_waddr_o, wb_wdata_o, rdata1_o);
    end
  endtask

  task automatic test_read_enables();
    re1_i = 0; raddr1_i = 5'd4;
    re2_i = 1; raddr2_i = 5'd4;
    #1;
    tests++;
    if (rdata1_o !== 32'h0 || rdata2_o !== 32'hAA) begin
      fails++; $display("FAIL read_enables: got %h %h expected 0 aa", rdata1_o, rdata2_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    set_exe(1'b1, 5'd5, 32'h1234);
    tick();
    set_exe(1'b1, 5'd6, 32'h77);
    tick();
    set_exe(1'b0, 5'd0, 32'h0);
    re1_i = 1; raddr1_i = 5'd5; re2_i = 1; raddr2_i = 5'd6;
    #1;
    tests++;
    if (rdata1_o !== 32'h1234 || rdata2_o !== 32'h77 || wb_we_o !== 1'b1) begin
      fails++; $display("FAIL pre_reset: got %h %h we=%b expected 1234 77 1", rdata1_o, rdata2_o, wb_we_o);
    end
    #1;
    rst_n_i = 1'b0;
    #1;
    tests++;
    if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0 || wb_we_o !== 1'b0 || wb_wdata_o !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: got %h %h we=%b d=%h expected 0 0 0 0", rdata1_o, rdata2_o, wb_we_o, wb_wdata_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      set_exe($urandom_range(0, 3) != 0, 5'($urandom_range(0, 9)), $urandom);
      stall_i  = ($urandom_range(0, 4) == 0);
      flush_i  = ($urandom_range(0, 9) == 0);
      re1_i    = ($urandom_range(0, 7) != 0);
      re2_i    = ($urandom_range(0, 7) != 0);
      raddr1_i = 5'($urandom_range(0, 9));
      raddr2_i = (c % 4 == 0) ? raddr1_i : 5'($urandom_range(0, 31));
      #1;
      tests++;
      if (rdata1_o !== model_read(re1_i, raddr1_i) || rdata2_o !== model_read(re2_i, raddr2_i)) begin
        fails++;
        $display("FAIL random_read c=%0d: got %h %h expected %h %h", c, rdata1_o, rdata2_o,
                 model_read(re1_i, raddr1_i), model_read(re2_i, raddr2_i));
      end
      tests++;
      if (wb_we_o !== m_we || wb_waddr_o !== m_wa || wb_wdata_o !== m_wd) begin
        fails++;
        $display("FAIL random_wb c=%0d: got %b %0d %h expected %b %0d %h", c, wb_we_o, wb_waddr_o, wb_wdata_o, m_we, m_wa, m_wd);
      end
      tick();
    end
    set_exe(1'b0, 5'd0, 32'h0);
    stall_i = 0; flush_i = 0;
    tick();
    tick();
    re1_i = 1;
    for (int r = 0; r < 32; r++) begin
      raddr1_i = 5'(r);
      #1;
      tests++;
      if (rdata1_o !== m_regs[r]) begin
        fails++; $display("FAIL array_sweep x%0d: got %h expected %h", r, rdata1_o, m_regs[r]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_x0();
    test_bypass_priority();
    test_stall_flush();
    test_read_enables();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
